// File: rtl/gpio_mmio_pkg.sv
// gpio_mmio_pkg: shared constants and types for the memory-mapped GPIO block.
// Holds the per-port register offsets, the per-port address stride and the
// register-select enum used by the address decoder and the port slices.
// Optional feature macro affecting this block: GPIO_DEBOUNCE_EN.
package gpio_mmio_pkg;

    // Word offsets of the registers inside one port window
    localparam logic [2:0] REG_DIN    = 3'd0;
    localparam logic [2:0] REG_DOUT   = 3'd1;
    localparam logic [2:0] REG_DIR    = 3'd2;
    localparam logic [2:0] REG_IRQ_EN = 3'd3;
    localparam logic [2:0] REG_PEND   = 3'd4;

    // Address distance between consecutive ports
    localparam int unsigned PORT_STRIDE = 8;

    typedef enum logic [2:0] {
        SEL_DIN    = REG_DIN,
        SEL_DOUT   = REG_DOUT,
        SEL_DIR    = REG_DIR,
        SEL_IRQ_EN = REG_IRQ_EN,
        SEL_PEND   = REG_PEND
    } reg_sel_e;

endpackage

// File: rtl/gpio_port.sv
// gpio_port: one GPIO port slice.
// Holds the 2-flop input synchronizer, the optional debounce filter, the
// DOUT/DIR/IRQ_EN/PEND registers and the rising-edge -> PEND logic.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   pin_i          raw asynchronous pin inputs
//   wr_i, sel_i    register write strobe (already decoded for this port) and register select
//   wdata_i        write data
//   din_o          filtered input value (DIN)
//   dout_o, dir_o, irq_en_o, pend_o   register contents
//   irq_c_o        combinational OR of PEND & IRQ_EN for this port
// Macro GPIO_DEBOUNCE_EN adds a per-port stability counter in front of DIN.
module gpio_port
    import gpio_mmio_pkg::*;
#(
    parameter int unsigned PORT_W = 24
`ifdef GPIO_DEBOUNCE_EN
    ,
    parameter int unsigned DEB_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PORT_W-1:0] pin_i,
    input  logic              wr_i,
    input  reg_sel_e          sel_i,
    input  logic [PORT_W-1:0] wdata_i,
    output logic [PORT_W-1:0] din_o,
    output logic [PORT_W-1:0] dout_o,
    output logic [PORT_W-1:0] dir_o,
    output logic [PORT_W-1:0] irq_en_o,
    output logic [PORT_W-1:0] pend_o,
    output logic              irq_c_o
);

    logic [PORT_W-1:0] sync1_q, sync2_q;
    logic [PORT_W-1:0] din_w, din_prev_q, rise_c;
    logic [PORT_W-1:0] dout_q, dout_d, dir_q, dir_d;
    logic [PORT_W-1:0] irq_en_q, irq_en_d, pend_q, pend_d;

    // Two-stage synchronizer for the asynchronous pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned     CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [PORT_W-1:0] cand_q, cand_d, deb_q, deb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // cand_q tracks the latest synchronized vector; cnt_q counts how many
    // cycles it has been present. DIN takes it once the count is complete.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            deb_d = cand_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q <= '0;
            cnt_q  <= '0;
            deb_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign din_w = deb_q;
`else
    assign din_w = sync2_q;
`endif

    assign rise_c = din_w & ~din_prev_q;

    // Register writes; a new rising edge overrides a same-cycle W1C
    always_comb begin
        dout_d   = dout_q;
        dir_d    = dir_q;
        irq_en_d = irq_en_q;
        pend_d   = pend_q | rise_c;
        if (wr_i) begin
            case (sel_i)
                SEL_DOUT:   dout_d   = wdata_i;
                SEL_DIR:    dir_d    = wdata_i;
                SEL_IRQ_EN: irq_en_d = wdata_i;
                SEL_PEND:   pend_d   = (pend_q & ~wdata_i) | rise_c;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_prev_q <= '0;
            dout_q     <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            pend_q     <= '0;
        end else begin
            din_prev_q <= din_w;
            dout_q     <= dout_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            pend_q     <= pend_d;
        end
    end

    assign din_o    = din_w;
    assign dout_o   = dout_q;
    assign dir_o    = dir_q;
    assign irq_en_o = irq_en_q;
    assign pend_o   = pend_q;
    assign irq_c_o  = |(pend_q & irq_en_q);

endmodule

// File: rtl/gpio_mmio.sv
// gpio_mmio: memory-mapped GPIO block with N_PORTS ports of PORT_W bits.
// Register window of port p starts at BASE_ADDR + 8*p: DIN, DOUT, DIR,
// IRQ_EN, PEND (W1C). Unmapped accesses return 0 with rvalid and pulse bus_err.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   addr, wdata, we, re   word-addressed single-cycle bus access
//   rdata, rvalid         read data, one cycle after re
//   bus_err               one-cycle pulse on an unmapped access
//   gpio_in               asynchronous pin inputs, port p at [p*PORT_W +: PORT_W]
//   gpio_out, gpio_oe     pin values / pin drive enables (DOUT / DIR)
//   irq                   level interrupt, OR of PEND & IRQ_EN over all ports
// Macro GPIO_DEBOUNCE_EN enables per-port input debouncing (DEB_CYCLES).
module gpio_mmio
    import gpio_mmio_pkg::*;
#(
    parameter int unsigned      N_PORTS    = 2,
    parameter int unsigned      PORT_W     = 24,
    parameter int unsigned      ADDR_W     = 24,
    parameter int unsigned      DATA_W     = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'('h001000),
    parameter int unsigned      DEB_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      we,
    input  logic                      re,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rvalid,
    output logic                      bus_err,
    input  logic [N_PORTS*PORT_W-1:0] gpio_in,
    output logic [N_PORTS*PORT_W-1:0] gpio_out,
    output logic [N_PORTS*PORT_W-1:0] gpio_oe,
    output logic                      irq
);

    localparam int unsigned SPAN  = PORT_STRIDE * N_PORTS;
    localparam int unsigned IDX_W = 3;

    // Elaboration-time parameter range checks
    if (N_PORTS < 1 || N_PORTS > 8) begin : g_bad_nports
        $error("gpio_mmio: N_PORTS must be 1..8");
    end
    if (PORT_W < 1 || PORT_W > DATA_W) begin : g_bad_portw
        $error("gpio_mmio: PORT_W must be 1..DATA_W");
    end
    if (ADDR_W < 6) begin : g_bad_addrw
        $error("gpio_mmio: ADDR_W must be at least 6");
    end
    if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb
        $error("gpio_mmio: DEB_CYCLES must be 2..65535");
    end

    logic [ADDR_W-1:0] off_c;
    logic              in_range_c, mapped_c, wr_c;
    logic [IDX_W-1:0]  port_c;
    reg_sel_e          sel_c;
    logic [PORT_W-1:0] rd_val_c;

    logic [PORT_W-1:0] din_w    [N_PORTS];
    logic [PORT_W-1:0] dout_w   [N_PORTS];
    logic [PORT_W-1:0] dir_w    [N_PORTS];
    logic [PORT_W-1:0] irq_en_w [N_PORTS];
    logic [PORT_W-1:0] pend_w   [N_PORTS];
    logic [N_PORTS-1:0] port_irq_c;

    logic              rst_done_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d, bus_err_q, bus_err_d, irq_q;

    // Address decode: block range, port index, register offset
    assign off_c      = addr - BASE_ADDR;
    assign in_range_c = (addr >= BASE_ADDR) && ({1'b0, off_c} < (ADDR_W+1)'(SPAN));
    assign port_c     = off_c[5:3];
    assign sel_c      = reg_sel_e'(off_c[2:0]);
    assign mapped_c   = in_range_c && (off_c[2:0] <= REG_PEND);
    // Accesses in the first cycle after reset release are dropped
    assign wr_c       = we && rst_done_q && mapped_c;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        gpio_port #(
            .PORT_W    (PORT_W)
`ifdef GPIO_DEBOUNCE_EN
            ,
            .DEB_CYCLES(DEB_CYCLES)
`endif
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .pin_i   (gpio_in[p*PORT_W +: PORT_W]),
            .wr_i    (wr_c && (port_c == IDX_W'(p))),
            .sel_i   (sel_c),
            .wdata_i (wdata[PORT_W-1:0]),
            .din_o   (din_w[p]),
            .dout_o  (dout_w[p]),
            .dir_o   (dir_w[p]),
            .irq_en_o(irq_en_w[p]),
            .pend_o  (pend_w[p]),
            .irq_c_o (port_irq_c[p])
        );
        assign gpio_out[p*PORT_W +: PORT_W] = dout_w[p];
        assign gpio_oe[p*PORT_W +: PORT_W]  = dir_w[p];
    end

    // Read mux over the pre-write register contents
    always_comb begin
        rd_val_c = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (port_c == IDX_W'(p)) begin
                case (sel_c)
                    SEL_DIN:    rd_val_c = din_w[p];
                    SEL_DOUT:   rd_val_c = dout_w[p];
                    SEL_DIR:    rd_val_c = dir_w[p];
                    SEL_IRQ_EN: rd_val_c = irq_en_w[p];
                    SEL_PEND:   rd_val_c = pend_w[p];
                    default:    rd_val_c = '0;
                endcase
            end
        end
    end

    // Bus response
    always_comb begin
        rdata_d   = '0;
        rvalid_d  = 1'b0;
        bus_err_d = 1'b0;
        if (rst_done_q) begin
            rvalid_d  = re;
            bus_err_d = (we || re) && !mapped_c;
            if (re && mapped_c) begin
                rdata_d = DATA_W'(rd_val_c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_done_q <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            bus_err_q  <= bus_err_d;
            irq_q      <= |port_irq_c;
        end
    end

    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign bus_err = bus_err_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_mmio.sv
// tb_gpio_mmio: self-checking bench for gpio_mmio (default parameters).
// A directed vector table, hand-written interrupt/W1C/reset sequences and a
// randomized phase, all checked against a cycle-level reference model that
// tracks the register contents and the pin history.
module tb_gpio_mmio;

    localparam int unsigned NP = 2;
    localparam int unsigned PW = 24;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 24;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic [DW-1:0]  wdata = '0;
    logic           we = 1'b0;
    logic           re = 1'b0;
    logic [DW-1:0]  rdata;
    logic           rvalid, bus_err, irq;
    logic [NP*PW-1:0] gpio_in = '0;
    logic [NP*PW-1:0] gpio_out, gpio_oe;

    always #5 clk = ~clk;

    gpio_mmio #(
        .N_PORTS(NP), .PORT_W(PW), .ADDR_W(AW), .DATA_W(DW),
        .BASE_ADDR(24'h001000), .DEB_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .rvalid(rvalid), .bus_err(bus_err),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: register contents plus the pins sampled at the last three edges
    logic [23:0] m_dout [2];
    logic [23:0] m_dir  [2];
    logic [23:0] m_ien  [2];
    logic [23:0] m_pend [2];
    logic [47:0] m_s1, m_s2, m_s3;
    bit          m_first;

    logic [23:0] last_rdata;
    logic        last_rv, last_err, last_irq;

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_dout[p] = '0; m_dir[p] = '0; m_ien[p] = '0; m_pend[p] = '0;
        end
        m_s1 = '0; m_s2 = '0; m_s3 = '0;
        m_first = 1'b1;
    endtask

    // Advance the model by one clock edge; returns the outputs expected after it
    task automatic model_edge(input logic w, input logic r, input logic [23:0] a,
                              input logic [23:0] d, output logic [23:0] e_rdata,
                              output logic e_rv, output logic e_err, output logic e_irq);
        bit          en;
        bit          mapped;
        int          off, port, rg;
        logic [23:0] val, w1c [2];
        logic [47:0] rise;
        en = !m_first;
        m_first = 1'b0;
        off = int'(a) - 32'h1000;
        mapped = (off >= 0) && (off < 16) && ((off % 8) <= 4);
        port = mapped ? off / 8 : 0;
        rg = mapped ? off % 8 : 0;
        case (rg)
            0: val = m_s2[port*24 +: 24];   // DIN lags the pins by two edges
            1: val = m_dout[port];
            2: val = m_dir[port];
            3: val = m_ien[port];
            default: val = m_pend[port];
        endcase
        e_irq   = (|(m_pend[0] & m_ien[0])) | (|(m_pend[1] & m_ien[1]));
        e_rv    = en & r;
        e_rdata = (en && r && mapped) ? val : 24'h0;
        e_err   = en && (w || r) && !mapped;
        rise = m_s2 & ~m_s3;
        w1c[0] = '0; w1c[1] = '0;
        if (en && w && mapped) begin
            case (rg)
                1: m_dout[port] = d;
                2: m_dir[port]  = d;
                3: m_ien[port]  = d;
                4: w1c[port]    = d;
                default: ;
            endcase
        end
        for (int p = 0; p < 2; p++) m_pend[p] = (m_pend[p] & ~w1c[p]) | rise[p*24 +: 24];
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = gpio_in;
    endtask

    // One bus cycle checked against the model
    task automatic step(input logic w, input logic r, input logic [23:0] a, input logic [23:0] d);
        logic [23:0] e_rdata;
        logic        e_rv, e_err, e_irq;
        we = w; re = r; addr = a; wdata = d;
        @(posedge clk);
        model_edge(w, r, a, d, e_rdata, e_rv, e_err, e_irq);
        #1;
        chk("rdata", 64'(rdata), 64'(e_rdata));
        chk("rvalid", 64'(rvalid), 64'(e_rv));
        chk("bus_err", 64'(bus_err), 64'(e_err));
        chk("irq", 64'(irq), 64'(e_irq));
        chk("gpio_out", 64'(gpio_out), 64'({m_dout[1], m_dout[0]}));
        chk("gpio_oe", 64'(gpio_oe), 64'({m_dir[1], m_dir[0]}));
        last_rdata = rdata; last_rv = rvalid; last_err = bus_err; last_irq = irq;
        we = 1'b0; re = 1'b0;
    endtask

`ifdef GPIO_DEBOUNCE_EN
    // Unmodelled bus cycle for the debounce sequence
    task automatic cyc(input logic w, input logic r, input logic [23:0] a, input logic [23:0] d);
        we = w; re = r; addr = a; wdata = d;
        @(posedge clk);
        #1;
        last_rdata = rdata; last_rv = rvalid; last_err = bus_err; last_irq = irq;
        we = 1'b0; re = 1'b0;
    endtask
`endif

    typedef struct {
        logic        w;
        logic        r;
        logic [23:0] a;
        logic [23:0] d;
        logic [23:0] x_rdata;
        logic        x_rv;
        logic        x_err;
        logic [47:0] x_out;
        logic [47:0] x_oe;
    } vec_t;

    vec_t vt [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic        rw, rr;
        logic [23:0] ra, rd;
        int          idx;

        vt[0]  = '{1'b1, 1'b0, 24'h001001, 24'hA5A5A5, 24'h0,      1'b0, 1'b0, 48'h000000A5A5A5, 48'h0};
        vt[1]  = '{1'b1, 1'b0, 24'h001002, 24'hFFFF00, 24'h0,      1'b0, 1'b0, 48'h000000A5A5A5, 48'h000000FFFF00};
        vt[2]  = '{1'b0, 1'b1, 24'h001001, 24'h0,      24'hA5A5A5, 1'b1, 1'b0, 48'h000000A5A5A5, 48'h000000FFFF00};
        vt[3]  = '{1'b0, 1'b1, 24'h001002, 24'h0,      24'hFFFF00, 1'b1, 1'b0, 48'h000000A5A5A5, 48'h000000FFFF00};
        vt[4]  = '{1'b0, 1'b1, 24'h001005, 24'h0,      24'h0,      1'b1, 1'b1, 48'h000000A5A5A5, 48'h000000FFFF00};
        vt[5]  = '{1'b0, 1'b1, 24'h001010, 24'h0,      24'h0,      1'b1, 1'b1, 48'h000000A5A5A5, 48'h000000FFFF00};
        vt[6]  = '{1'b1, 1'b0, 24'h001011, 24'h123456, 24'h0,      1'b0, 1'b1, 48'h000000A5A5A5, 48'h000000FFFF00};
        vt[7]  = '{1'b0, 1'b1, 24'h000FFF, 24'h0,      24'h0,      1'b1, 1'b1, 48'h000000A5A5A5, 48'h000000FFFF00};
        vt[8]  = '{1'b1, 1'b0, 24'h001009, 24'h00FF00, 24'h0,      1'b0, 1'b0, 48'h00FF00A5A5A5, 48'h000000FFFF00};
        vt[9]  = '{1'b1, 1'b1, 24'h001001, 24'h111111, 24'hA5A5A5, 1'b1, 1'b0, 48'h00FF00111111, 48'h000000FFFF00};
        vt[10] = '{1'b0, 1'b1, 24'h001001, 24'h0,      24'h111111, 1'b1, 1'b0, 48'h00FF00111111, 48'h000000FFFF00};
        vt[11] = '{1'b1, 1'b0, 24'h001000, 24'hFFFFFF, 24'h0,      1'b0, 1'b0, 48'h00FF00111111, 48'h000000FFFF00};
        vt[12] = '{1'b0, 1'b1, 24'h001000, 24'h0,      24'h0,      1'b1, 1'b0, 48'h00FF00111111, 48'h000000FFFF00};
        vt[13] = '{1'b0, 1'b1, 24'h001009, 24'h0,      24'h00FF00, 1'b1, 1'b0, 48'h00FF00111111, 48'h000000FFFF00};

        // Reset values while rst is held low
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset.rdata", 64'(rdata), 64'h0);
        chk("reset.rvalid", 64'(rvalid), 64'h0);
        chk("reset.bus_err", 64'(bus_err), 64'h0);
        chk("reset.irq", 64'(irq), 64'h0);
        chk("reset.gpio_out", 64'(gpio_out), 64'h0);
        chk("reset.gpio_oe", 64'(gpio_oe), 64'h0);
        @(negedge clk);
        rst = 1'b1;

        // Write in the reset-release cycle is dropped
        step(1'b1, 1'b0, 24'h001001, 24'hFFFFFF);
        chk("release_write_ignored", 64'(gpio_out), 64'h0);

        // Directed register-map vectors
        for (int i = 0; i < 14; i++) begin
            step(vt[i].w, vt[i].r, vt[i].a, vt[i].d);
            chk($sformatf("vec%0d.rdata", i), 64'(last_rdata), 64'(vt[i].x_rdata));
            chk($sformatf("vec%0d.rvalid", i), 64'(last_rv), 64'(vt[i].x_rv));
            chk($sformatf("vec%0d.bus_err", i), 64'(last_err), 64'(vt[i].x_err));
            chk($sformatf("vec%0d.gpio_out", i), 64'(gpio_out), 64'(vt[i].x_out));
            chk($sformatf("vec%0d.gpio_oe", i), 64'(gpio_oe), 64'(vt[i].x_oe));
        end

`ifndef GPIO_DEBOUNCE_EN
        // Port 1 bit 0 rising edge -> DIN, PEND, irq, then W1C
        step(1'b1, 1'b0, 24'h00100B, 24'h000001);
        gpio_in[24] = 1'b1;
        step(1'b0, 1'b0, 24'h0, 24'h0);
        step(1'b0, 1'b0, 24'h0, 24'h0);
        step(1'b0, 1'b1, 24'h001008, 24'h0);
        chk("p1.din_t2", 64'(last_rdata), 64'h1);
        step(1'b0, 1'b1, 24'h00100C, 24'h0);
        chk("p1.pend", 64'(last_rdata), 64'h1);
        chk("p1.irq_set", 64'(last_irq), 64'h1);
        step(1'b1, 1'b0, 24'h00100C, 24'h000001);
        step(1'b0, 1'b1, 24'h00100C, 24'h0);
        chk("p1.pend_cleared", 64'(last_rdata), 64'h0);
        chk("p1.irq_dropped", 64'(last_irq), 64'h0);

        // Port 0 bit 0 rising edge coincident with W1C of the same bit
        gpio_in[0] = 1'b1;
        step(1'b0, 1'b0, 24'h0, 24'h0);
        step(1'b0, 1'b0, 24'h0, 24'h0);
        step(1'b1, 1'b0, 24'h001004, 24'h000001);
        step(1'b0, 1'b1, 24'h001004, 24'h0);
        chk("set_beats_w1c", 64'(last_rdata), 64'h1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rw = ($urandom_range(0, 2) == 0);
            rr = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 15) == 0) ? 24'h000FFF : 24'h001000 + 24'($urandom_range(0, 19));
            rd = 24'($urandom);
`ifndef GPIO_DEBOUNCE_EN
            if ($urandom_range(0, 3) == 0) begin
                idx = int'($urandom_range(0, 47));
                gpio_in[idx] = ~gpio_in[idx];
            end
`endif
            step(rw, rr, ra, rd);
        end

        // Asynchronous reset in the middle of a read with DOUT and irq set
        step(1'b1, 1'b0, 24'h001001, 24'hA5A5A5);
        step(1'b1, 1'b0, 24'h001003, 24'hFFFFFF);
        gpio_in = '0;
        repeat (4) step(1'b0, 1'b0, 24'h0, 24'h0);
`ifndef GPIO_DEBOUNCE_EN
        gpio_in[5] = 1'b1;
        repeat (4) step(1'b0, 1'b0, 24'h0, 24'h0);
        chk("pre_reset.irq", 64'(irq), 64'h1);
`endif
        step(1'b0, 1'b1, 24'h001001, 24'h0);
        chk("pre_reset.rvalid", 64'(rvalid), 64'h1);
        chk("pre_reset.rdata", 64'(rdata), 64'hA5A5A5);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset.gpio_out", 64'(gpio_out), 64'h0);
        chk("async_reset.gpio_oe", 64'(gpio_oe), 64'h0);
        chk("async_reset.irq", 64'(irq), 64'h0);
        chk("async_reset.rvalid", 64'(rvalid), 64'h0);
        chk("async_reset.rdata", 64'(rdata), 64'h0);
        chk("async_reset.bus_err", 64'(bus_err), 64'h0);
        gpio_in = '0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 24'h0, 24'h0);
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < 5; r++) begin
                step(1'b0, 1'b1, 24'h001000 + 24'(8 * p + r), 24'h0);
                chk($sformatf("post_reset.p%0d.r%0d", p, r), 64'(last_rdata), 64'h0);
            end
        end

`ifdef GPIO_DEBOUNCE_EN
        // Toggling every 5 cycles never settles; a steady level does
        for (int k = 0; k < 8; k++) begin
            gpio_in[0] = ~gpio_in[0];
            for (int c = 0; c < 5; c++) begin
                cyc(1'b0, 1'b1, 24'h001000, 24'h0);
                chk("deb.toggle_din", 64'(last_rdata), 64'h0);
            end
        end
        gpio_in[0] = 1'b1;
        cyc(1'b0, 1'b0, 24'h0, 24'h0);
        repeat (16) cyc(1'b0, 1'b0, 24'h0, 24'h0);
        cyc(1'b0, 1'b1, 24'h001000, 24'h0);
        chk("deb.din_t17", 64'(last_rdata), 64'h0);
        cyc(1'b0, 1'b1, 24'h001000, 24'h0);
        chk("deb.din_t18", 64'(last_rdata), 64'h1);
        cyc(1'b0, 1'b0, 24'h0, 24'h0);
        cyc(1'b0, 1'b1, 24'h001004, 24'h0);
        chk("deb.pend", 64'(last_rdata), 64'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gpio_mmio.md
GPIO_MMIO -- requirements
Module: gpio_mmio

Interface
REQ-001 Parameter N_PORTS, default 2: number of GPIO ports, 1..8.
REQ-002 Parameter PORT_W, default 24: bits per port, 1..DATA_W.
REQ-003 Parameter ADDR_W, default 24: word-address width.
REQ-004 Parameter DATA_W, default 24: bus data width.
REQ-005 Parameter BASE_ADDR, default 24'h001000: word address of port 0, register 0.
REQ-006 Parameter DEB_CYCLES, default 16: debounce stability count, 2..65535.
REQ-007 One clock; reset is asynchronous and active-low. Ports are named clk and rst.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 rst  input  1  asynchronous active-low reset.
REQ-010 addr  input  ADDR_W  word address.
REQ-011 wdata  input  DATA_W  write data.
REQ-012 we  input  1  write strobe, single cycle.
REQ-013 re  input  1  read strobe, single cycle.
REQ-014 rdata  output  DATA_W  read data, valid with rvalid.
REQ-015 rvalid  output  1  read-data-valid pulse.
REQ-016 bus_err  output  1  pulse on an access to an unmapped address.
REQ-017 gpio_in  input  N_PORTS*PORT_W  asynchronous pin inputs; port p occupies bits [p*PORT_W +: PORT_W].
REQ-018 gpio_out  output  N_PORTS*PORT_W  pin output values.
REQ-019 gpio_oe  output  N_PORTS*PORT_W  pin output enables; 1 means drive.
REQ-020 irq  output  1  level interrupt.

Function
REQ-021 Register map: port p, register r is at BASE_ADDR + 8*p + r, with r as follows.
- 0 DIN: read-only, filtered input.
- 1 DOUT: read/write.
- 2 DIR: read/write.
- 3 IRQ_EN: read/write.
- 4 PEND: write-1-to-clear.
REQ-022 Register bits above PORT_W-1 shall read 0 and shall ignore writes.
REQ-023 The following accesses are unmapped:
- offsets 5..7;
- ports >= N_PORTS;
- addresses outside the block range.
An unmapped access shall cause no state change, return rdata=0 with rvalid, and pulse bus_err for one cycle at the same edge.
REQ-024 Read latency is one cycle: re sampled high at edge t gives rvalid=1 and rdata valid after edge t, for exactly one cycle.
REQ-025 Writes take effect at the edge where we is sampled high.
REQ-026 If we and re are both high at the same address in one cycle, rdata shall return the pre-write value.
REQ-027 gpio_out = DOUT and gpio_oe = DIR, registered, with no extra delay after the write edge.
REQ-028 Each input bit shall pass through a 2-flop synchronizer.
REQ-029 Without debounce, DIN equals the second synchronizer stage. An input change set up before edge t is readable in DIN from edge t+2.
REQ-030 A rising edge is DIN=1 while the previous-cycle DIN=0. It shall set the corresponding PEND bit at the next edge, regardless of IRQ_EN.
REQ-031 If a PEND set and a W1C clear hit the same bit in the same cycle, the set wins.
REQ-032 irq = OR over all ports of (PEND & IRQ_EN), registered, with one cycle latency after the PEND/IRQ_EN update.

Reset
REQ-033 While rst=0, the following shall be forced to 0 asynchronously:
- all registers;
- synchronizers;
- debounce state;
- rdata, rvalid, bus_err;
- gpio_out, gpio_oe, irq.
REQ-034 A bus access in the cycle of reset deassertion shall be ignored. Reset asserted mid-read shall suppress rvalid.
REQ-035 Input edges are not detected until two edges after reset release, because DIN starts at 0.

Configuration
REQ-036 Macro GPIO_DEBOUNCE_EN defined: DIN for each port shall update to the synchronized vector only after that vector has remained unchanged for DEB_CYCLES consecutive cycles. A per-port counter shall restart on any bit change, and edge detection shall operate on the debounced DIN.
REQ-037 Macro GPIO_DEBOUNCE_EN undefined: no counters shall exist, and DIN shall be as stated in REQ-029.

Structure
REQ-038 Package gpio_mmio_pkg shall hold:
- register offset constants (REG_DIN..REG_PEND);
- the port stride constant 8;
- a register-select enum.
REQ-039 Sub-module gpio_port, instantiated N_PORTS times, shall hold one port's synchronizer, debounce logic, registers and edge/PEND logic. The top shall own address decode and the read mux.

Verification
REQ-040 Write 24'hA5A5A5 to 0x001001, then write 24'hFFFF00 to 0x001002 -> gpio_out[23:0]=A5A5A5 and gpio_oe[23:0]=FFFF00 the cycle after each write; reading 0x001001 returns A5A5A5 with rvalid one cycle after re.
REQ-041 Set gpio_in[24] 0->1 with macro undefined and IRQ_EN(port1)=1 -> reading 0x001008 returns 1 from edge t+2, PEND(0x00100C) bit0=1, irq=1; writing 1 to 0x00100C clears PEND and drops irq.
REQ-042 Rising edge on bit0 coincident with W1C of bit0 -> PEND bit0 remains 1.
REQ-043 Read 0x001005, then read 0x001010 (N_PORTS=2) -> rdata=0, rvalid=1, bus_err one-cycle pulse, no register change.
REQ-044 With GPIO_DEBOUNCE_EN and DEB_CYCLES=16, toggle gpio_in[0] at 5-cycle intervals -> DIN stays 0; hold the input at 1 for 20 cycles -> DIN=1 after 2+16 cycles.
REQ-045 Assert rst=0 mid-operation with DOUT=A5A5A5 and irq=1 -> all outputs are 0 immediately without a clock edge; after release, all registers read 0.
